serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured on accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while in SHIFT.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: sum  output  WIDTH  result; stable from the done pulse until the next accepted start.
REQ-011 SHALL have port: cout  output  1  final carry-out; same validity as sum.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1, load a, b and cin into the operand shift registers and carry flop, clear the bit counter, and go to SHIFT.
REQ-014 SHALL, each SHIFT cycle, compute one full-adder bit from A[0], B[0] and the carry flop: sum bit = A^B^C, carry = AB | C(A|B).
REQ-015 SHALL, each SHIFT cycle, shift the sum bit into the result register MSB-first-in, right-shift the operands, and update the carry flop.
REQ-016 SHALL process bits LSB first and spend exactly WIDTH cycles in SHIFT, then go to DONE.
REQ-017 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-018 SHALL give latency from the start-sampling edge to done high of WIDTH+1 cycles; a new start is accepted at the earliest in the cycle after done.
REQ-019 SHALL ignore start while in SHIFT or DONE; captured operands and the result are unaffected.
REQ-020 SHALL make sum and cout equal to (a + b + cin) mod 2^(WIDTH+1), with cout as bit WIDTH.
REQ-021 SHALL size the bit counter to ceil(log2(WIDTH+1)) bits, with no wrap before WIDTH.
REQ-022 SHALL keep busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-SHIFT, immediately force: state IDLE; busy 0; done 0; sum 0; cout 0; counter 0; carry flop 0; operand registers 0.
REQ-024 SHALL, after rst_n deasserts, accept start no earlier than the first rising edge at which rst_n is high; a partial result from an interrupted addition is never presented.

Configuration
REQ-025 SHALL, when SERIAL_ADDER_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow, equal to the carry into the MSB XOR cout.
REQ-026 SHALL give ovf the same validity and reset value (0) as cout.
REQ-027 SHALL, when SERIAL_ADDER_OVF_EN is undefined, omit the ovf port and its logic entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state encoding type (IDLE, SHIFT, DONE) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-029 SHALL implement the one-bit add as sub-module fa_bit (inputs a, b, c; outputs s, co; purely combinational), instantiated once.
REQ-030 SHALL keep the FSM, counter, shift registers and carry flop in serial_adder itself.

Verification
REQ-031 SHALL cover basic add: WIDTH=8, a=0x35, b=0x4A, cin=0 -> done 9 cycles after start; sum=0x7F, cout=0.
REQ-032 SHALL cover full carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with cin=1 and a=0xFF, b=0x00 -> sum=0x00, cout=1.
REQ-033 SHALL cover ignored start: start pulsed with a=0x11, b=0x22 during SHIFT of 0x10+0x20 -> result 0x30; no second done.
REQ-034 SHALL cover reset mid-operation: rst_n low at SHIFT cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; a new add of 0x01+0x01 then gives 0x02.
REQ-035 SHALL cover back-to-back: a start in the cycle after done (0x80+0x80) is accepted -> sum=0x00, cout=1; ovf=1 when SERIAL_ADDER_OVF_EN is defined.
REQ-036 SHALL cover random regression: 1000 random a, b, cin, WIDTH in {2, 8, 16} -> {cout,sum} matches the reference model every time; done always one cycle wide.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and the default operand width live here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder used by the serial adder datapath; purely combinational.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a | b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH cycles in SHIFT, LSB first, then a one-cycle done pulse.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    fa_bit u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .c  (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result fills from the top so bit 0 lands at the LSB after WIDTH shifts.
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    carry <= c_bit;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ c_bit;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The carry flop holds the final carry from the end of SHIFT until the next start.
    assign cout      = carry;
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 2, 8 and 16 with a behavioural model.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int N = 3;
    localparam int WID [N] = '{2, 8, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] start_v = '0;
    logic [N-1:0] cin_v = '0;
    logic [15:0]  a_v [N];
    logic [15:0]  b_v [N];
    logic [N-1:0] busy_v, done_v, cout_v, ovf_v;
    logic [15:0]  sum_v [N];
    logic [1:0]   st_v [N];
    logic [1:0]   sum2;
    logic [7:0]   sum8;
    logic [15:0]  sum16;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;

    serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][1:0]), .b(b_v[0][1:0]),
        .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum2), .cout(cout_v[0]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[0]),
`endif
        .fsm_state(st_v[0])
    );

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum8), .cout(cout_v[1]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[1]),
`endif
        .fsm_state(st_v[1])
    );

    serial_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .cout(cout_v[2]),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[2]),
`endif
        .fsm_state(st_v[2])
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_v = '0;
`endif
    assign sum_v[0] = 16'(sum2);
    assign sum_v[1] = 16'(sum8);
    assign sum_v[2] = sum16;

    task automatic chk(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (width %0d, cycle %0d): got 0x%0h, expected 0x%0h", nm, w, cyc, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer addition, masked to the operand width.
    function automatic logic [16:0] model_sum(input int w, input logic [15:0] x, input logic [15:0] y, input logic c);
        longint m = (longint'(1) << w) - 1;
        longint r = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
        return 17'(r);
    endfunction

    function automatic logic model_ovf(input int w, input logic [15:0] x, input logic [15:0] y, input logic c);
        longint half = longint'(1) << (w - 1);
        longint m = (half << 1) - 1;
        longint ux = longint'(x) & m;
        longint uy = longint'(y) & m;
        longint sx = (ux >= half) ? ux - 2 * half : ux;
        longint sy = (uy >= half) ? uy - 2 * half : uy;
        longint s = sx + sy + longint'(c);
        return (s > half - 1) || (s < -half);
    endfunction

    // Model state: an accepted start at cycle t produces done at cycle t+W; the
    // result then holds until the next accepted start.
    bit          pend [N];
    bit          res_ok [N];
    int          done_at [N];
    logic [16:0] exp_res [N];
    logic        exp_ovf [N];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                pend[i] = 1'b0;
                res_ok[i] = 1'b1;
                exp_res[i] = '0;
                exp_ovf[i] = 1'b0;
            end else if (start_v[i] && (!pend[i] || cyc >= done_at[i] + 2)) begin
                pend[i] = 1'b1;
                res_ok[i] = 1'b0;
                done_at[i] = cyc + WID[i];
                exp_res[i] = model_sum(WID[i], a_v[i], b_v[i], cin_v[i]);
                exp_ovf[i] = model_ovf(WID[i], a_v[i], b_v[i], cin_v[i]);
                n_acc++;
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            logic [15:0] m;
            m = 16'((longint'(1) << WID[i]) - 1);
            chk("busy", WID[i], 32'(busy_v[i]), 32'(pend[i] && cyc < done_at[i]));
            chk("done", WID[i], 32'(done_v[i]), 32'(pend[i] && cyc == done_at[i]));
            if (pend[i] && cyc == done_at[i]) res_ok[i] = 1'b1;
            if (res_ok[i]) begin
                chk("sum", WID[i], 32'(sum_v[i]), 32'(exp_res[i][15:0] & m));
                chk("cout", WID[i], 32'(cout_v[i]), 32'(exp_res[i][WID[i]]));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", WID[i], 32'(ovf_v[i]), 32'(exp_ovf[i]));
`endif
            end
        end
    end

    task automatic wait_done(input int i, input int t0, output logic [15:0] s, output logic co,
                             output logic ov, output int lat);
        lat = -1;
        s = '0;
        co = 1'b0;
        ov = 1'b0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                lat = cyc - t0;
                s = sum_v[i];
                co = cout_v[i];
                ov = ovf_v[i];
            end
        end
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_add(input int i, input logic [15:0] x, input logic [15:0] y, input logic c,
                           output logic [15:0] s, output logic co, output logic ov, output int lat);
        int t0;
        a_v[i] = x;
        b_v[i] = y;
        cin_v[i] = c;
        start_v[i] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[i] = 1'b0;
        wait_done(i, t0, s, co, ov, lat);
    endtask

    initial begin
        logic [15:0] s;
        logic        co, ov;
        int          lat, t0, extra, base;

        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("reset_state", WID[i], 32'(st_v[i]), 32'(IDLE));
            chk("reset_busy", WID[i], 32'(busy_v[i]), 0);
            chk("reset_sum", WID[i], 32'(sum_v[i]), 0);
        end
        rst_n = 1'b1;

        run_add(1, 16'h35, 16'h4A, 1'b0, s, co, ov, lat);
        chk("basic_latency", 8, 32'(lat), 9);
        chk("basic_sum", 8, 32'(s), 32'h7F);
        chk("basic_cout", 8, 32'(co), 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("basic_ovf", 8, 32'(ov), 0);
`endif
        run_add(1, 16'h80, 16'h80, 1'b0, s, co, ov, lat);
        chk("b2b_latency", 8, 32'(lat), 9);
        chk("b2b_sum", 8, 32'(s), 32'h00);
        chk("b2b_cout", 8, 32'(co), 1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("b2b_ovf", 8, 32'(ov), 1);
`endif
        run_add(1, 16'hFF, 16'h01, 1'b0, s, co, ov, lat);
        chk("chain_sum", 8, 32'(s), 32'h00);
        chk("chain_cout", 8, 32'(co), 1);
        run_add(1, 16'hFF, 16'h00, 1'b1, s, co, ov, lat);
        chk("chain_cin_sum", 8, 32'(s), 32'h00);
        chk("chain_cin_cout", 8, 32'(co), 1);

        // A second start during SHIFT must not disturb the running addition.
        a_v[1] = 16'h10;
        b_v[1] = 16'h20;
        cin_v[1] = 1'b0;
        start_v[1] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        a_v[1] = 16'h11;
        b_v[1] = 16'h22;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_done(1, t0, s, co, ov, lat);
        chk("ignored_latency", 8, 32'(lat), 9);
        chk("ignored_sum", 8, 32'(s), 32'h30);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[1]) extra++;
        end
        chk("ignored_no_second_done", 8, 32'(extra), 0);

        // Reset in the fourth SHIFT cycle, with nonzero partial sum and carry.
        a_v[1] = 16'h55;
        b_v[1] = 16'h55;
        cin_v[1] = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 8, 32'(busy_v[1]), 0);
        chk("midrst_done", 8, 32'(done_v[1]), 0);
        chk("midrst_sum", 8, 32'(sum_v[1]), 0);
        chk("midrst_cout", 8, 32'(cout_v[1]), 0);
        rst_n = 1'b1;
        run_add(1, 16'h01, 16'h01, 1'b0, s, co, ov, lat);
        chk("postrst_latency", 8, 32'(lat), 9);
        chk("postrst_sum", 8, 32'(s), 32'h02);
        chk("postrst_cout", 8, 32'(co), 0);

        // Random regression on all three widths at once.
        base = n_acc;
        for (int k = 0; k < 20000 && (n_acc - base) < 1000; k++) begin
            for (int i = 0; i < N; i++) begin
                start_v[i] = 1'($urandom_range(0, 1));
                a_v[i] = 16'($urandom);
                b_v[i] = 16'($urandom);
                cin_v[i] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start_v = '0;
        repeat (20) @(negedge clk);
        chk("regress_count", 0, 32'((n_acc - base) >= 1000), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
